// File: rtl/picomips_sequencer.sv
// picoMIPS program counter and stall controller: sequences the PC, executes HOLD
// by parking on a target until the debounced switch leaves the requested level.
module picomips_sequencer #(
    parameter int Psize     = 5,
    parameter int Isize     = 15,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] I,
    input  logic             sw_hold,
    output logic [Psize-1:0] address,
    output logic             wr_en,
    output logic             holding,
    output logic             sw_clean
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [2:0] OP_HOLD = 3'b100;

    typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

    state_t           state;
    state_t           next_state;
    logic [Psize-1:0] pc_next;
    logic             s1;
    logic             s2;
    logic [CW-1:0]    cnt;
    logic             is_hold;
    logic             level;
    logic [Psize-1:0] target;
    logic             unused_bits;

    assign is_hold     = (I[Isize-1:Isize-3] == OP_HOLD);
    assign level       = I[7];
    assign target      = I[Psize-1:0];
    assign unused_bits = ^{I[Isize-4:8], I[6:Psize]};

    // The switch counter only advances while the synchronised level disagrees
    // with the accepted one, so any shorter pulse is silently discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            sw_clean <= 1'b0;
            cnt      <= '0;
        end else begin
            s1 <= sw_hold;
            s2 <= s1;
            if (s2 == sw_clean) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                sw_clean <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            address <= '0;
        end else begin
            state   <= next_state;
            address <= pc_next;
        end
    end

    always_comb begin
        next_state = state;
        pc_next    = address;
        case (state)
            BOOT: begin
                next_state = RUN;
                pc_next    = '0;
            end
            RUN, WAIT: begin
                if (is_hold && (sw_clean == level)) begin
                    next_state = WAIT;
                    pc_next    = target;
                end else begin
                    next_state = RUN;
                    pc_next    = address + 1'b1;
                end
            end
            default: begin
                next_state = BOOT;
                pc_next    = '0;
            end
        endcase
    end

    assign wr_en   = (state != BOOT) && !is_hold;
    assign holding = (state == WAIT);

endmodule
